// File: rtl/tx_axis_arbiter_if.sv
// AXI-stream bundle between the upstream sources and the TX MAC arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface tx_axis_arbiter_if #(
  parameter int NUM_PORTS        = 2,
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH  = XGMII_DATA_WIDTH / 8
);
  logic [NUM_PORTS*XGMII_DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep;
  logic [NUM_PORTS-1:0]                  s_axis_tvalid;
  logic [NUM_PORTS-1:0]                  s_axis_tlast;
  logic [NUM_PORTS-1:0]                  s_axis_trdy;
  logic [XGMII_DATA_WIDTH-1:0]           m_axis_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]            m_axis_tkeep;
  logic                                  m_axis_tvalid;
  logic                                  m_axis_tlast;
  logic                                  m_axis_trdy;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
    output s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
    input  s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/tx_axis_arbiter.sv
// Frame-granular round-robin arbiter feeding the single TX MAC stream input.
// A grant is locked from the first beat until tlast is accepted; per-frame stats are reported.
module tx_axis_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH  = XGMII_DATA_WIDTH / 8,
  parameter int BEAT_CNT_WIDTH   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_PORTS-1:0]         i_port_en,
  tx_axis_arbiter_if.slave             axis,
  output logic [NUM_PORTS-1:0]         o_grant,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic [$clog2(NUM_PORTS)-1:0] o_frame_port,
  output logic [BEAT_CNT_WIDTH-1:0]    o_frame_beats
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int DW    = XGMII_DATA_WIDTH;
  localparam int KW    = AXIS_KEEP_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e                    state_r;
  logic [IDX_W-1:0]          grant_idx_r;
  logic [IDX_W-1:0]          last_idx_r;
  logic [NUM_PORTS-1:0]      grant_r;
  logic                      busy_r;
  logic                      frame_done_r;
  logic [IDX_W-1:0]          frame_port_r;
  logic [BEAT_CNT_WIDTH-1:0] frame_beats_r;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_r;

  logic [NUM_PORTS-1:0]      req_s;
  logic [IDX_W-1:0]          winner_s;
  logic                      xfer_s;
  logic [DW-1:0]             sel_tdata_s;
  logic [KW-1:0]             sel_tkeep_s;
  logic                      sel_tvalid_s;
  logic                      sel_tlast_s;
  logic                      m_tvalid_s;
  logic                      m_tlast_s;
  logic                      accept_s;
  logic [BEAT_CNT_WIDTH-1:0] beat_inc_s;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] last, input int k);
    rr_next = IDX_W'((int'(last) + k) % NUM_PORTS);
  endfunction

  // Round-robin winner: nearest requester after last_idx (descending loop, nearest assigned last)
  always_comb begin
    req_s    = axis.s_axis_tvalid & i_port_en;
    winner_s = last_idx_r;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      winner_s = req_s[rr_next(last_idx_r, k)] ? rr_next(last_idx_r, k) : winner_s;
    end
  end

  // Combinational mux of the locked port onto the MAC stream
  always_comb begin
    sel_tdata_s  = {DW{1'b0}};
    sel_tkeep_s  = {KW{1'b0}};
    sel_tvalid_s = 1'b0;
    sel_tlast_s  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_tdata_s  = (grant_idx_r == IDX_W'(p)) ? axis.s_axis_tdata[p*DW +: DW] : sel_tdata_s;
      sel_tkeep_s  = (grant_idx_r == IDX_W'(p)) ? axis.s_axis_tkeep[p*KW +: KW] : sel_tkeep_s;
      sel_tvalid_s = (grant_idx_r == IDX_W'(p)) ? axis.s_axis_tvalid[p]        : sel_tvalid_s;
      sel_tlast_s  = (grant_idx_r == IDX_W'(p)) ? axis.s_axis_tlast[p]         : sel_tlast_s;
    end
  end

  // Handshake qualification and saturating beat increment
  always_comb begin
    xfer_s     = (state_r == ST_XFER);
    m_tvalid_s = xfer_s & sel_tvalid_s;
    m_tlast_s  = xfer_s & sel_tlast_s;
    accept_s   = m_tvalid_s & axis.m_axis_trdy;
    beat_inc_s = (beat_cnt_r == {BEAT_CNT_WIDTH{1'b1}}) ? beat_cnt_r
                                                         : beat_cnt_r + {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // grant_r is zero outside XFER, so it alone routes the sink's ready back
  assign axis.s_axis_trdy   = grant_r & {NUM_PORTS{axis.m_axis_trdy}};
  assign axis.m_axis_tdata  = sel_tdata_s;
  assign axis.m_axis_tkeep  = sel_tkeep_s;
  assign axis.m_axis_tvalid = m_tvalid_s;
  assign axis.m_axis_tlast  = m_tlast_s;

  assign o_grant       = grant_r;
  assign o_busy        = busy_r;
  assign o_frame_done  = frame_done_r;
  assign o_frame_port  = frame_port_r;
  assign o_frame_beats = frame_beats_r;

  // Arbitration FSM with frame lock and completion statistics
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= ST_IDLE;
      grant_idx_r   <= {IDX_W{1'b0}};
      last_idx_r    <= IDX_W'(NUM_PORTS - 1);
      grant_r       <= {NUM_PORTS{1'b0}};
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_port_r  <= {IDX_W{1'b0}};
      frame_beats_r <= {BEAT_CNT_WIDTH{1'b0}};
      beat_cnt_r    <= {BEAT_CNT_WIDTH{1'b0}};
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            grant_idx_r <= winner_s;
            grant_r     <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner_s;
            beat_cnt_r  <= {BEAT_CNT_WIDTH{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept_s) begin
            beat_cnt_r <= beat_inc_s;
            if (m_tlast_s) begin
              last_idx_r    <= grant_idx_r;
              frame_port_r  <= grant_idx_r;
              frame_beats_r <= beat_inc_s;
              frame_done_r  <= 1'b1;
              grant_r       <= {NUM_PORTS{1'b0}};
              busy_r        <= 1'b0;
              state_r       <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Scoreboard bench for tx_axis_arbiter: a 4-port instance for arbitration/data checks
// and a 2-port instance with a 4-bit beat counter for saturation.
`timescale 1ns/1ps
module tb_tx_axis_arbiter;
  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] port_en;
  logic [NP-1:0] grant;
  logic          busy, done;
  logic [1:0]    fport;
  logic [BW-1:0] fbeats;

  logic [1:0]    s_en;
  logic [1:0]    s_grant;
  logic          s_busy, s_done;
  logic [0:0]    s_fport;
  logic [3:0]    s_fbeats;

  tx_axis_arbiter_if #(.NUM_PORTS(NP), .XGMII_DATA_WIDTH(DW)) bus ();
  tx_axis_arbiter_if #(.NUM_PORTS(2),  .XGMII_DATA_WIDTH(DW)) sbus ();

  tx_axis_arbiter #(.NUM_PORTS(NP), .XGMII_DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_port_en(port_en), .axis(bus.slave),
    .o_grant(grant), .o_busy(busy), .o_frame_done(done),
    .o_frame_port(fport), .o_frame_beats(fbeats)
  );

  tx_axis_arbiter #(.NUM_PORTS(2), .XGMII_DATA_WIDTH(DW), .BEAT_CNT_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_port_en(s_en), .axis(sbus.slave),
    .o_grant(s_grant), .o_busy(s_busy), .o_frame_done(s_done),
    .o_frame_port(s_fport), .o_frame_beats(s_fbeats)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int port;
    int beats;
  } frm_t;

  beat_t exp_beats[$];
  frm_t  exp_frames[$];

  logic [DW-1:0] src_data [NP][DEPTH];
  logic [KW-1:0] src_keep [NP][DEPTH];
  logic          src_last [NP][DEPTH];
  int            src_len  [NP];
  int            src_pos  [NP];
  int            hs_cnt   [NP];
  logic [NP-1:0] stall;
  bit            trdy_toggle;

  int errors = 0;
  int checks = 0;
  int idle_run = 0;
  int sat_done_cnt = 0;
  int sat_fbeats = 0;
  int sat_fport = 0;
  beat_t mon_b;
  frm_t  mon_f;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      if (src_pos[p] < src_len[p]) begin
        bus.s_axis_tvalid[p]         = ~stall[p];
        bus.s_axis_tdata[p*DW +: DW] = src_data[p][src_pos[p]];
        bus.s_axis_tkeep[p*KW +: KW] = src_keep[p][src_pos[p]];
        bus.s_axis_tlast[p]          = src_last[p][src_pos[p]];
      end else begin
        bus.s_axis_tvalid[p]         = 1'b0;
        bus.s_axis_tdata[p*DW +: DW] = '0;
        bus.s_axis_tkeep[p*KW +: KW] = '0;
        bus.s_axis_tlast[p]          = 1'b0;
      end
    end
  endtask

  // Load a frame into port p's source; when exp_on, push its beats and stats in grant order
  task automatic add_frame(input int p, input int fid, input int n, input bit exp_on);
    beat_t b;
    frm_t  f;
    for (int i = 0; i < n; i++) begin
      b.port = p;
      b.data = {8'(p), 8'(fid), 16'(i)};
      b.keep = (i == n - 1) ? 4'h7 : 4'hF;
      b.last = (i == n - 1);
      src_data[p][src_len[p]] = b.data;
      src_keep[p][src_len[p]] = b.keep;
      src_last[p][src_len[p]] = b.last;
      src_len[p]++;
      if (exp_on) exp_beats.push_back(b);
    end
    if (exp_on) begin
      f.port  = p;
      f.beats = n;
      exp_frames.push_back(f);
    end
  endtask

  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clk);
    hs = bus.s_axis_tvalid & bus.s_axis_trdy;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        src_pos[p]++;
        hs_cnt[p]++;
      end
    end
    bus.m_axis_trdy = trdy_toggle ? ~bus.m_axis_trdy : 1'b1;
    drive_src();
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
      hs_cnt[p]  = 0;
    end
    stall = '0;
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    exp_beats.delete();
    exp_frames.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_frames.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats and %0d frames outstanding, expected 0",
               name, exp_beats.size(), exp_frames.size());
    end
    step();
    step();
  endtask

  // Monitor: pops the scoreboard on every MAC beat and every completion pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_axis_tvalid && bus.m_axis_trdy) begin
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra: got data %0h from grant %0h, expected no beat",
                   bus.m_axis_tdata, grant);
        end else begin
          mon_b = exp_beats.pop_front();
          check("beat_data", bus.m_axis_tdata, mon_b.data);
          check("beat_keep", bus.m_axis_tkeep, mon_b.keep);
          check("beat_last", bus.m_axis_tlast, mon_b.last);
          check("beat_grant", grant, NP'(1) << mon_b.port);
        end
      end
      if (done) begin
        if (exp_frames.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra: got pulse port %0d beats %0d, expected none", fport, fbeats);
        end else begin
          mon_f = exp_frames.pop_front();
          check("frame_port", fport, mon_f.port);
          check("frame_beats", fbeats, mon_f.beats);
          check("bubble_grant", grant, 0);
        end
      end
      if (busy) check("trdy_route", bus.s_axis_trdy, grant & {NP{bus.m_axis_trdy}});
      if (grant == '0 && (bus.s_axis_tvalid & port_en) != '0) begin
        idle_run++;
      end else if (grant != '0 && idle_run > 0) begin
        check("idle_gap", idle_run, 1);
        idle_run = 0;
      end else if (grant == '0) begin
        idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
  end

  // Completion capture for the saturation instance
  always @(negedge clk) begin
    if (rst_n && s_done) begin
      sat_done_cnt++;
      sat_fbeats = int'(s_fbeats);
      sat_fport  = int'(s_fport);
    end
  end

  initial begin
    int bad;
    int sb;
    logic shs;

    port_en           = '1;
    trdy_toggle       = 1'b0;
    bus.m_axis_trdy   = 1'b1;
    s_en              = 2'b11;
    sbus.s_axis_tdata = '0;
    sbus.s_axis_tkeep = '1;
    sbus.s_axis_tvalid = '0;
    sbus.s_axis_tlast = '0;
    sbus.m_axis_trdy  = 1'b1;
    clear_src();

    #23;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fport", fport, 0);
    check("rst_fbeats", fbeats, 0);
    check("rst_mvalid", bus.m_axis_tvalid, 0);
    check("rst_strdy", bus.s_axis_trdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single port, 16-beat frame
    add_frame(0, 0, 16, 1'b1);
    drive_src();
    wait_drain("single", 100);

    // Round robin with all four ports busy
    do_reset();
    add_frame(0, 0, 3, 1'b1);
    add_frame(1, 0, 3, 1'b1);
    add_frame(2, 0, 3, 1'b1);
    add_frame(3, 0, 3, 1'b1);
    add_frame(0, 1, 3, 1'b1);
    drive_src();
    wait_drain("round_robin", 200);

    // Backpressure: sink ready toggles every cycle
    do_reset();
    trdy_toggle = 1'b1;
    add_frame(2, 0, 8, 1'b1);
    drive_src();
    wait_drain("backpressure", 100);
    check("bp_handshakes", hs_cnt[2], 8);
    trdy_toggle = 1'b0;
    bus.m_axis_trdy = 1'b1;

    // Enable mask, with port 1 disabled mid-frame
    do_reset();
    port_en = 4'b1010;
    add_frame(1, 0, 6, 1'b1);
    add_frame(3, 0, 3, 1'b1);
    add_frame(3, 1, 3, 1'b1);
    add_frame(0, 0, 3, 1'b0);
    add_frame(2, 0, 3, 1'b0);
    add_frame(1, 1, 3, 1'b0);
    drive_src();
    repeat (3) step();
    port_en = 4'b1000;
    wait_drain("enable_mask", 100);
    repeat (4) step();
    check("en_no_grant", grant, 0);
    port_en = '1;

    // Source stall for 50 cycles mid-frame while port 1 also requests
    do_reset();
    add_frame(0, 0, 8, 1'b1);
    add_frame(1, 0, 3, 1'b1);
    drive_src();
    for (int i = 0; i < 50 && src_pos[0] < 3; i++) step();
    check("stall_reach", src_pos[0], 3);
    stall[0] = 1'b1;
    drive_src();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant !== 4'b0001 || bus.m_axis_tvalid !== 1'b0) bad++;
    end
    check("stall_hold", bad, 0);
    stall[0] = 1'b0;
    drive_src();
    wait_drain("stall", 100);

    // Asynchronous reset during beat 5
    do_reset();
    add_frame(0, 0, 16, 1'b1);
    drive_src();
    for (int i = 0; i < 50 && src_pos[0] < 5; i++) step();
    check("arst_reach", src_pos[0], 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_mvalid", bus.m_axis_tvalid, 0);
    check("arst_strdy", bus.s_axis_trdy, 0);
    clear_src();
    exp_beats.delete();
    exp_frames.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_frame(0, 1, 4, 1'b1);
    add_frame(1, 0, 3, 1'b1);
    drive_src();
    wait_drain("post_reset", 100);

    // Saturation: 20-beat frame through a 4-bit beat counter
    sb = 0;
    sbus.s_axis_tvalid = 2'b01;
    for (int c = 0; c < 100 && sb < 20; c++) begin
      sbus.s_axis_tdata[DW-1:0] = 32'(sb);
      sbus.s_axis_tlast[0]      = (sb == 19);
      @(negedge clk);
      shs = sbus.s_axis_tvalid[0] & sbus.s_axis_trdy[0];
      if (shs) check("sat_data", sbus.m_axis_tdata, sb);
      @(posedge clk);
      #1;
      if (shs) sb++;
    end
    sbus.s_axis_tvalid = '0;
    sbus.s_axis_tlast  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("sat_sent", sb, 20);
    check("sat_done_cnt", sat_done_cnt, 1);
    check("sat_beats", sat_fbeats, 15);
    check("sat_port", sat_fport, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
